// File: rtl/riffa_chnl_echo.sv
// RIFFA channel echo: each RX transaction is buffered through a small FIFO and
// returned as one TX transaction of identical length and data order.
module riffa_chnl_echo #(
    parameter int unsigned C_PCI_DATA_WIDTH = 128,
    parameter int unsigned C_FIFO_DEPTH     = 16
) (
    input  logic                        USER_CLK,
    input  logic                        USER_RESET_N,
    output logic                        CHNL_RX_CLK,
    input  logic                        CHNL_RX,
    output logic                        CHNL_RX_ACK,
    input  logic                        CHNL_RX_LAST,
    input  logic [31:0]                 CHNL_RX_LEN,
    input  logic [30:0]                 CHNL_RX_OFF,
    input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
    input  logic                        CHNL_RX_DATA_VALID,
    output logic                        CHNL_RX_DATA_REN,
    output logic                        CHNL_TX_CLK,
    output logic                        CHNL_TX,
    input  logic                        CHNL_TX_ACK,
    output logic                        CHNL_TX_LAST,
    output logic [31:0]                 CHNL_TX_LEN,
    output logic [30:0]                 CHNL_TX_OFF,
    output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
    output logic                        CHNL_TX_DATA_VALID,
    input  logic                        CHNL_TX_DATA_REN,
    output logic [15:0]                 ECHO_COUNT
);

    localparam int unsigned PtrW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StAck, StXfer, StDone} state_e;

    state_e              state_q, state_d;
    logic [31:0]         len_q, len_d;
    logic [30:0]         rx_rem_q, rx_rem_d;
    logic [30:0]         tx_rem_q, tx_rem_d;
    logic [PtrW-1:0]     wptr_q, wptr_d;
    logic [PtrW-1:0]     rptr_q, rptr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [15:0]         echo_cnt_q, echo_cnt_d;
    logic                tx_ack_q, tx_ack_d;
    logic [C_PCI_DATA_WIDTH-1:0] mem_q [C_FIFO_DEPTH];

    logic        fifo_full, fifo_empty, in_xfer, tx_req, push, pop;
    logic [30:0] rx_beats;
    logic        unused_sig;

    assign CHNL_RX_CLK = USER_CLK;
    assign CHNL_TX_CLK = USER_CLK;

    // ceil(len/4) cannot overflow 31 bits even for len = 2^32-1
    assign rx_beats = {1'b0, CHNL_RX_LEN[31:2]} + {30'd0, |CHNL_RX_LEN[1:0]};

    assign fifo_full  = (cnt_q == CntW'(C_FIFO_DEPTH));
    assign fifo_empty = (cnt_q == '0);
    assign in_xfer    = (state_q == StXfer);
    assign tx_req     = in_xfer || ((state_q == StAck) && (len_q != '0));
    assign push       = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
    assign pop        = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;

    assign CHNL_RX_ACK        = (state_q == StAck);
    assign CHNL_RX_DATA_REN   = in_xfer && !fifo_full && (rx_rem_q != '0);
    assign CHNL_TX_DATA_VALID = in_xfer && !fifo_empty;
    assign CHNL_TX_DATA       = mem_q[rptr_q];
    assign CHNL_TX            = tx_req;
    assign CHNL_TX_LAST       = tx_req;
    assign CHNL_TX_LEN        = tx_req ? len_q : '0;
    assign CHNL_TX_OFF        = '0;
    assign ECHO_COUNT         = echo_cnt_q;

    // TX_ACK is captured for observability only; it never throttles data
    assign unused_sig = ^{CHNL_RX_LAST, CHNL_RX_OFF, tx_ack_q};

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        rx_rem_d   = rx_rem_q;
        tx_rem_d   = tx_rem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
        echo_cnt_d = echo_cnt_q;
        tx_ack_d   = tx_ack_q | (tx_req & CHNL_TX_ACK);

        if (push) begin
            wptr_d   = wptr_q + PtrW'(1);
            rx_rem_d = rx_rem_q - 31'd1;
        end
        if (pop) begin
            rptr_d   = rptr_q + PtrW'(1);
            tx_rem_d = tx_rem_q - 31'd1;
        end

        unique case (state_q)
            StIdle: begin
                tx_ack_d = 1'b0;
                if (CHNL_RX) begin
                    state_d  = StAck;
                    len_d    = CHNL_RX_LEN;
                    rx_rem_d = rx_beats;
                    tx_rem_d = rx_beats;
                end
            end
            StAck: begin
                if (len_q != '0) begin
                    state_d = StXfer;
                end else begin
                    state_d    = StDone;
                    echo_cnt_d = echo_cnt_q + 16'd1;
                end
            end
            StXfer: begin
                if (pop && (tx_rem_q == 31'd1)) begin
                    state_d    = StDone;
                    echo_cnt_d = echo_cnt_q + 16'd1;
                end
            end
            StDone: begin
                if (!CHNL_RX) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge USER_CLK) begin
        if (!USER_RESET_N) begin
            state_q    <= StIdle;
            len_q      <= '0;
            rx_rem_q   <= '0;
            tx_rem_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            echo_cnt_q <= '0;
            tx_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            rx_rem_q   <= rx_rem_d;
            tx_rem_q   <= tx_rem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            echo_cnt_q <= echo_cnt_d;
            tx_ack_q   <= tx_ack_d;
        end
    end

    always_ff @(posedge USER_CLK) begin
        if (push) begin
            mem_q[wptr_q] <= CHNL_RX_DATA;
        end
    end

endmodule
